// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one buart transmitter between NREQ byte producers.
// An owner keeps the UART until it sends a byte flagged last or idles for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [1:0]        owner,
  output logic              locked,
  input  logic              uart_busy,
  output logic              uart_wr,
  output logic [7:0]        uart_data
);

  typedef enum logic [1:0] {ST_ARB, ST_WAIT, ST_STROBE, ST_SETTLE} state_t;

  localparam bit         TIMEOUT_EN = (LOCK_TIMEOUT != 0);
  localparam logic [7:0] TMAX       = 8'(LOCK_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [7:0]  timer;
  logic        last_q;

  logic [3:0]  req_pad;
  logic [3:0]  last_pad;
  logic [31:0] data_pad;
  logic [7:0]  data_arr [4];
  logic [1:0]  winner;
  logic [1:0]  rr_next;
  logic [2:0]  idx;
  logic [2:0]  nxt;
  logic        found;

  // Pad request vectors to the 4-slot maximum so every index is in range for any NREQ.
  assign req_pad  = 4'(req);
  assign last_pad = 4'(req_last);
  assign data_pad = 32'(req_data);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data_arr[i] = data_pad[8*i +: 8];
    end
  end

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + 3'(k);
      if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
      if (!found && req_pad[idx[1:0]]) begin
        winner = idx[1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    nxt     = {1'b0, owner} + 3'd1;
    rr_next = (nxt >= 3'(NREQ)) ? 2'd0 : nxt[1:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state     <= ST_ARB;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      locked    <= 1'b0;
      uart_wr   <= 1'b0;
      ack       <= '0;
      uart_data <= 8'h00;
      timer     <= 8'd0;
      last_q    <= 1'b0;
    end else begin
      uart_wr <= 1'b0;
      ack     <= '0;
      case (state)
        ST_ARB: begin
          if (|req) begin
            owner  <= winner;
            locked <= 1'b1;
            timer  <= 8'd0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (req_pad[owner]) begin
            if (!uart_busy) begin
              uart_data <= data_arr[owner];
              last_q    <= last_pad[owner];
              uart_wr   <= 1'b1;
              ack       <= NREQ'(4'b0001 << owner);
              state     <= ST_STROBE;
            end else begin
              timer <= 8'd0;
            end
          end else begin
            timer <= (timer == 8'hFF) ? timer : timer + 8'd1;
            if (TIMEOUT_EN && timer == TMAX) begin
              locked <= 1'b0;
              rr_ptr <= rr_next;
              state  <= ST_ARB;
            end
          end
        end
        ST_STROBE: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Dead cycle lets buart raise busy before the owner's next byte is considered.
          if (last_q) begin
            locked <= 1'b0;
            rr_ptr <= rr_next;
            state  <= ST_ARB;
          end else begin
            timer <= 8'd0;
            state <= ST_WAIT;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule
